// File: rtl/frame_blitter.sv
// Raster-order image blitter: sweeps an IMG_W x IMG_H frame ROM and emits one clipped,
// optionally colour-keyed pixel per clock to the VGA adapter, with a busy/done handshake.
module frame_blitter #(
    parameter int unsigned IMG_W      = 160,
    parameter int unsigned IMG_H      = 120,
    parameter int unsigned SCR_W      = 160,
    parameter int unsigned SCR_H      = 120,
    parameter int unsigned COLOUR_W   = 3,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned NUM_FRAMES = 7,
    parameter int unsigned FSEL_W     = 3,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned KEY_EN     = 0,
    parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0
) (
    input  logic                           iClock,
    input  logic                           iReset,
    input  logic                           iStart,
    input  logic                           iAbort,
    input  logic [FSEL_W-1:0]              iFrame,
    input  logic [7:0]                     iX0,
    input  logic [6:0]                     iY0,
    output logic [ADDR_W-1:0]              oAddr,
    input  logic [NUM_FRAMES*COLOUR_W-1:0] iRomData,
    output logic [7:0]                     oX,
    output logic [6:0]                     oY,
    output logic [COLOUR_W-1:0]            oColour,
    output logic                           oPlot,
    output logic                           oBusy,
    output logic                           oDone
);
    localparam int unsigned N     = IMG_W * IMG_H;
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned FL_W  = $clog2(ROM_LAT + 1);

    typedef enum logic [1:0] {StIdle, StDraw, StFlush, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [FSEL_W-1:0]   frame_q, frame_d;
    logic [7:0]          x0_q, x0_d;
    logic [6:0]          y0_q, y0_d;
    logic [FL_W-1:0]     flush_q, flush_d;

    logic [ROM_LAT-1:0]  vld_q;
    logic [COL_W-1:0]    col_pipe_q [ROM_LAT];
    logic [ROW_W-1:0]    row_pipe_q [ROM_LAT];

    logic [7:0]          x_q;
    logic [6:0]          y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q;

    logic                abort_clr;
    logic [COLOUR_W-1:0] rom_colour;
    logic [8:0]          x_sum;
    logic [7:0]          y_sum;
    logic                pix_vis;

    assign abort_clr = iAbort && (state_q == StDraw || state_q == StFlush);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        frame_d = frame_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        flush_d = flush_q;
        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    state_d = StDraw;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    frame_d = iFrame;
                    x0_d    = iX0;
                    y0_d    = iY0;
                    flush_d = '0;
                end
            end
            StDraw: begin
                if (addr_q == ADDR_W'(N - 1)) begin
                    state_d = StFlush;
                    flush_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (col_q == COL_W'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            StFlush: begin
                if (flush_q == FL_W'(ROM_LAT)) state_d = StDone;
                else                           flush_d = flush_q + FL_W'(1);
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_clr) state_d = StIdle;
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            frame_q <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            frame_q <= frame_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            flush_q <= flush_d;
        end
    end

    // Delay line aligning pixel coordinates with the ROM read latency.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            vld_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                col_pipe_q[i] <= '0;
                row_pipe_q[i] <= '0;
            end
        end else begin
            if (abort_clr) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= (state_q == StDraw);
                for (int i = 1; i < ROM_LAT; i++) vld_q[i] <= vld_q[i-1];
            end
            col_pipe_q[0] <= col_q;
            row_pipe_q[0] <= row_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                col_pipe_q[i] <= col_pipe_q[i-1];
                row_pipe_q[i] <= row_pipe_q[i-1];
            end
        end
    end

    // Out-of-range frame indices match no slice and read as colour 0.
    always_comb begin
        rom_colour = '0;
        for (int f = 0; f < NUM_FRAMES; f++) begin
            if (frame_q == FSEL_W'(f)) rom_colour = iRomData[f*COLOUR_W +: COLOUR_W];
        end
    end

    assign x_sum   = 9'(x0_q) + 9'(col_pipe_q[ROM_LAT-1]);
    assign y_sum   = 8'(y0_q) + 8'(row_pipe_q[ROM_LAT-1]);
    assign pix_vis = vld_q[ROM_LAT-1] && (32'(x_sum) < SCR_W) && (32'(y_sum) < SCR_H) &&
                     !((KEY_EN != 0) && (rom_colour == KEY_COLOUR));

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            plot_q <= pix_vis && !abort_clr;
            if (vld_q[ROM_LAT-1]) begin
                x_q      <= x_sum[7:0];
                y_q      <= y_sum[6:0];
                colour_q <= rom_colour;
            end
        end
    end

    assign oAddr   = addr_q;
    assign oX      = x_q;
    assign oY      = y_q;
    assign oColour = colour_q;
    assign oPlot   = plot_q;
    assign oBusy   = (state_q != StIdle);
    assign oDone   = (state_q == StDone);
endmodule
